// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite slot scheduler.
// A slot holding EMPTY_ID is free; free slots also carry zero coordinates.
package sprite_pkg;

  localparam int NUM_SLOTS = 16;
  localparam int SLOT_W    = 4;
  localparam int COORD_W   = 10;
  localparam int ID_W      = 4;
  localparam logic [ID_W-1:0] EMPTY_ID = 4'hF;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_ALLOC = 2'b01,
    CMD_MOVE  = 2'b10,
    CMD_FREE  = 2'b11
  } sprite_cmd_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } sprite_entry_t;

  localparam sprite_entry_t EMPTY_ENTRY = '{id: EMPTY_ID, x: '0, y: '0};

endpackage

// File: rtl/sprite_slot_sched_rr_arb2.sv
// Two-way round-robin arbiter. When both request, the one not granted most
// recently wins; the preference only moves when i_en marks a taken grant.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic r_prio;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = r_prio ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_prio <= 1'b0;
    end else if (i_en && (o_gnt != 2'b00)) begin
      r_prio <= o_gnt[0];
    end
  end

endmodule

// File: rtl/sprite_slot_sched.sv
// Sprite slot table controller: two arbitrated requesters edit a shadow table
// that is copied to the renderer-facing active table at each vsync falling edge.
module sprite_slot_sched
  import sprite_pkg::*;
(
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               vs,
  input  logic [1:0]                         req_valid,
  output logic [1:0]                         req_ready,
  input  logic [1:0][1:0]                    req_cmd,
  input  logic [1:0][3:0]                    req_slot,
  input  logic [1:0][ID_W-1:0]               req_id,
  input  logic [1:0][COORD_W-1:0]            req_x,
  input  logic [1:0][COORD_W-1:0]            req_y,
  output logic [1:0]                         rsp_valid,
  output logic [3:0]                         rsp_slot,
  output logic                               rsp_err,
  output logic [NUM_SLOTS-1:0][COORD_W-1:0]  PosX,
  output logic [NUM_SLOTS-1:0][COORD_W-1:0]  PosY,
  output logic [NUM_SLOTS-1:0][ID_W-1:0]     SpriteID,
  output logic                               frame_tick
);

  sched_state_e r_state;
  sched_state_e w_state_next;

  logic [1:0] w_arb_req;
  logic [1:0] w_gnt;
  logic       w_accept;
  logic       w_sel;

  sprite_cmd_e        r_cmd;
  logic               r_who;
  logic [SLOT_W-1:0]  r_slot;
  logic [ID_W-1:0]    r_id;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;

  sprite_entry_t r_shadow [NUM_SLOTS];
  sprite_entry_t r_active [NUM_SLOTS];

  logic              w_free_found;
  logic [SLOT_W-1:0] w_free_idx;

  logic              w_exec;
  logic              w_wr_en;
  logic [SLOT_W-1:0] w_wr_slot;
  sprite_entry_t     w_wr_entry;
  logic [SLOT_W-1:0] w_exec_slot;
  logic              w_exec_err;

  logic r_vs;
  logic w_swap;

  // Arbitration only happens in IDLE; requests are masked during EXEC and reset.
  assign w_arb_req = ((r_state == S_IDLE) && !Reset) ? req_valid : 2'b00;
  assign w_accept  = |w_gnt;
  assign w_sel     = w_gnt[1];
  assign w_exec    = (r_state == S_EXEC);
  assign w_swap    = r_vs & ~vs;

  rr_arb2 u_arb (
    .i_clk  (Clk),
    .i_srst (Reset),
    .i_req  (w_arb_req),
    .i_en   (w_accept),
    .o_gnt  (w_gnt)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = w_gnt;
    rsp_valid  = 2'b00;
    rsp_slot   = '0;
    rsp_err    = 1'b0;
    frame_tick = w_swap && !Reset;
    if (w_exec && !Reset) begin
      rsp_valid = r_who ? 2'b10 : 2'b01;
      rsp_slot  = w_exec_slot;
      rsp_err   = w_exec_err;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cmd  <= CMD_NOP;
      r_who  <= 1'b0;
      r_slot <= '0;
      r_id   <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end else if (w_accept) begin
      r_cmd  <= sprite_cmd_e'(req_cmd[w_sel]);
      r_who  <= w_sel;
      r_slot <= req_slot[w_sel];
      r_id   <= req_id[w_sel];
      r_x    <= req_x[w_sel];
      r_y    <= req_y[w_sel];
    end
  end

  // Scanning downward lets the lowest free index win.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (r_shadow[i].id == EMPTY_ID) begin
        w_free_found = 1'b1;
        w_free_idx   = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_slot   = r_slot;
    w_wr_entry  = r_shadow[r_slot];
    w_exec_slot = r_slot;
    w_exec_err  = 1'b0;
    case (r_cmd)
      CMD_ALLOC: begin
        if (!w_free_found || (r_id == EMPTY_ID)) begin
          w_exec_err  = 1'b1;
          w_exec_slot = '0;
        end else begin
          w_wr_en     = 1'b1;
          w_wr_slot   = w_free_idx;
          w_exec_slot = w_free_idx;
          w_wr_entry  = '{id: r_id, x: r_x, y: r_y};
        end
      end
      CMD_MOVE: begin
        if (r_shadow[r_slot].id == EMPTY_ID) begin
          w_exec_err = 1'b1;
        end else begin
          w_wr_en      = 1'b1;
          w_wr_entry.x = r_x;
          w_wr_entry.y = r_y;
        end
      end
      CMD_FREE: begin
        if (r_shadow[r_slot].id == EMPTY_ID) begin
          w_exec_err = 1'b1;
        end else begin
          w_wr_en    = 1'b1;
          w_wr_entry = EMPTY_ENTRY;
        end
      end
      default: ;
    endcase
    w_wr_en = w_wr_en && w_exec;
  end

  // The swap copies the pre-edge shadow, so a same-cycle EXEC write waits a frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vs <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_shadow[i] <= EMPTY_ENTRY;
        r_active[i] <= EMPTY_ENTRY;
      end
    end else begin
      r_vs <= vs;
      if (w_swap) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end
      if (w_wr_en) begin
        r_shadow[w_wr_slot] <= w_wr_entry;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_out
    assign PosX[gi]     = r_active[gi].x;
    assign PosY[gi]     = r_active[gi].y;
    assign SpriteID[gi] = r_active[gi].id;
  end

endmodule

// File: tb/tb_sprite_slot_sched.sv
// Directed bench for sprite_slot_sched: drivers queue expected responses,
// a negedge monitor pops and compares them as the DUT responds.
`timescale 1ns/1ps
module tb_sprite_slot_sched;
  import sprite_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic vs = 1'b1;
  logic [1:0]              req_valid = '0;
  logic [1:0]              req_ready;
  logic [1:0][1:0]         req_cmd = '0;
  logic [1:0][3:0]         req_slot = '0;
  logic [1:0][3:0]         req_id = '0;
  logic [1:0][9:0]         req_x = '0;
  logic [1:0][9:0]         req_y = '0;
  logic [1:0]              rsp_valid;
  logic [3:0]              rsp_slot;
  logic                    rsp_err;
  logic [15:0][9:0]        PosX;
  logic [15:0][9:0]        PosY;
  logic [15:0][3:0]        SpriteID;
  logic                    frame_tick;

  sprite_slot_sched dut (
    .Clk(Clk), .Reset(Reset), .vs(vs),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_slot(req_slot), .req_id(req_id), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_slot(rsp_slot), .rsp_err(rsp_err),
    .PosX(PosX), .PosY(PosY), .SpriteID(SpriteID), .frame_tick(frame_tick)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [4:0] q0[$];
  logic [4:0] q1[$];
  int grants[$];
  logic prev_ready = 1'b0;
  logic [3:0] m_id[16];
  logic [9:0] m_x[16];
  logic [9:0] m_y[16];
  logic [3:0] s0[4] = '{4'd1, 4'd2, 4'd4, 4'd10};
  logic [3:0] s1[4] = '{4'd5, 4'd6, 4'd8, 4'd9};

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response scoreboard and ready/grant observer.
  always @(negedge Clk) begin
    logic [4:0] e;
    if (rsp_valid != 2'b00) chk("rsp_onehot", rsp_valid == 2'b11, 1'b0);
    for (int r = 0; r < 2; r++) begin
      if (rsp_valid[r]) begin
        if ((r == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          n_vec++;
          n_bad++;
          $display("FAIL rsp_unexpected: requester %0d responded, none expected", r);
        end else begin
          e = (r == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("rsp_slot_r%0d", r), rsp_slot, e[4:1]);
          chk($sformatf("rsp_err_r%0d", r), rsp_err, e[0]);
        end
      end
    end
    if (req_ready != 2'b00) begin
      chk("ready_gap", prev_ready, 1'b0);
      chk("ready_onehot", req_ready == 2'b11, 1'b0);
      if ((req_ready & req_valid) != 2'b00) grants.push_back(req_ready[1] ? 1 : 0);
    end
    prev_ready = |req_ready;
  end

  // mode 0: normal, 1: vs falls during EXEC, 2: reset asserted during EXEC
  task automatic send(input int r, input sprite_cmd_e cmd, input logic [3:0] slot,
                      input logic [3:0] id, input logic [9:0] x, input logic [9:0] y,
                      input logic [3:0] exp_slot, input logic exp_err, input int mode);
    int n;
    @(posedge Clk); #1;
    req_cmd[r] = cmd; req_slot[r] = slot; req_id[r] = id; req_x[r] = x; req_y[r] = y;
    req_valid[r] = 1'b1;
    if (mode != 2) begin
      if (r == 0) q0.push_back({exp_slot, exp_err});
      else        q1.push_back({exp_slot, exp_err});
    end
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!req_ready[r] && n < 50);
    if (!req_ready[r]) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: requester %0d never saw req_ready", r);
      req_valid[r] = 1'b0;
      return;
    end
    @(posedge Clk); #1;
    req_valid[r] = 1'b0;
    if (mode == 1) vs = 1'b0;
    if (mode == 2) Reset = 1'b1;
    @(negedge Clk);
    if (mode == 2) begin
      chk("rsp_during_reset", rsp_valid, 2'b00);
    end else begin
      chk($sformatf("rsp_latency_r%0d", r), rsp_valid[r], 1'b1);
    end
    if (mode == 1) begin
      chk("tick_in_exec", frame_tick, 1'b1);
      @(posedge Clk); #1;
      vs = 1'b1;
      @(negedge Clk);
    end
  endtask

  task automatic do_swap();
    @(posedge Clk); #1;
    vs = 1'b0;
    @(negedge Clk);
    chk("frame_tick_hi", frame_tick, 1'b1);
    @(posedge Clk); #1;
    vs = 1'b1;
    @(negedge Clk);
    chk("frame_tick_lo", frame_tick, 1'b0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_id[i] = 4'hF; m_x[i] = '0; m_y[i] = '0;
    end
  endtask

  task automatic check_table(input string tag);
    logic [15:0][3:0] e_id;
    logic [15:0][9:0] e_x;
    logic [15:0][9:0] e_y;
    for (int i = 0; i < 16; i++) begin
      e_id[i] = m_id[i]; e_x[i] = m_x[i]; e_y[i] = m_y[i];
    end
    chk({tag, "_id"}, SpriteID, e_id);
    chk({tag, "_x"}, PosX, e_x);
    chk({tag, "_y"}, PosY, e_y);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_ready", req_ready, 2'b00);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_rsp_slot", rsp_slot, 4'd0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_tick", frame_tick, 1'b0);
    check_table("reset");
    @(posedge Clk); #1;
    Reset = 1'b0;

    // First allocation stays invisible until the next swap.
    send(0, CMD_ALLOC, 4'd0, 4'd5, 10'd100, 10'd200, 4'd0, 1'b0, 0);
    chk("pre_swap_id0", SpriteID[0], 4'hF);
    m_id[0] = 4'd5; m_x[0] = 10'd100; m_y[0] = 10'd200;
    do_swap();
    check_table("first_alloc");

    // Fill every slot, then overflow.
    for (int i = 1; i < 16; i++) begin
      send(i % 2, CMD_ALLOC, 4'd0, 4'(i % 15), 10'(i * 10), 10'(i * 20), 4'(i), 1'b0, 0);
      m_id[i] = 4'(i % 15); m_x[i] = 10'(i * 10); m_y[i] = 10'(i * 20);
    end
    send(0, CMD_ALLOC, 4'd0, 4'd2, 10'd1, 10'd1, 4'd0, 1'b1, 0);
    do_swap();
    check_table("full");
    send(1, CMD_FREE, 4'd7, 4'd0, 10'd0, 10'd0, 4'd7, 1'b0, 0);
    send(0, CMD_ALLOC, 4'd0, 4'd9, 10'd7, 10'd8, 4'd7, 1'b0, 0);
    m_id[7] = 4'd9; m_x[7] = 10'd7; m_y[7] = 10'd8;
    do_swap();
    check_table("refill7");

    // Error cases on an emptied slot 3 and an ALLOC of the empty ID.
    send(1, CMD_FREE, 4'd3, 4'd0, 10'd0, 10'd0, 4'd3, 1'b0, 0);
    m_id[3] = 4'hF; m_x[3] = '0; m_y[3] = '0;
    send(0, CMD_MOVE, 4'd3, 4'd0, 10'd1, 10'd1, 4'd3, 1'b1, 0);
    send(1, CMD_FREE, 4'd3, 4'd0, 10'd0, 10'd0, 4'd3, 1'b1, 0);
    send(0, CMD_ALLOC, 4'd0, 4'hF, 10'd9, 10'd9, 4'd0, 1'b1, 0);
    do_swap();
    check_table("errors");

    // Both requesters continuously valid; requester 0 went last so 1 goes first.
    grants.delete();
    fork
      begin
        for (int k = 0; k < 4; k++)
          send(0, CMD_MOVE, s0[k], 4'd0, 10'(300 + k), 10'(400 + k), s0[k], 1'b0, 0);
      end
      begin
        for (int k = 0; k < 4; k++)
          send(1, CMD_MOVE, s1[k], 4'd0, 10'(500 + k), 10'(600 + k), s1[k], 1'b0, 0);
      end
    join
    chk("grant_count", grants.size(), 8);
    for (int k = 0; k < grants.size() && k < 8; k++)
      chk($sformatf("grant_order_%0d", k), grants[k], (k % 2 == 0) ? 1 : 0);
    for (int k = 0; k < 4; k++) begin
      m_x[s0[k]] = 10'(300 + k); m_y[s0[k]] = 10'(400 + k);
      m_x[s1[k]] = 10'(500 + k); m_y[s1[k]] = 10'(600 + k);
    end
    do_swap();
    check_table("fair_moves");

    // MOVE executing on the swap cycle shows up one frame later.
    send(0, CMD_MOVE, 4'd0, 4'd0, 10'd50, 10'd60, 4'd0, 1'b0, 1);
    check_table("swap_coincide_old");
    m_x[0] = 10'd50; m_y[0] = 10'd60;
    do_swap();
    check_table("swap_coincide_new");

    // Reset during EXEC: no response, everything back to reset values.
    send(1, CMD_FREE, 4'd2, 4'd0, 10'd0, 10'd0, 4'd2, 1'b0, 2);
    @(negedge Clk);
    model_clear();
    check_table("mid_reset");
    chk("mid_reset_rsp", rsp_valid, 2'b00);
    chk("mid_reset_ready", req_ready, 2'b00);
    chk("mid_reset_tick", frame_tick, 1'b0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    send(1, CMD_ALLOC, 4'd0, 4'd3, 10'd11, 10'd12, 4'd0, 1'b0, 0);
    m_id[0] = 4'd3; m_x[0] = 10'd11; m_y[0] = 10'd12;
    do_swap();
    check_table("after_reset");

    repeat (3) @(negedge Clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
